imem_loader: RTL and testbench



---
 rtl/imem_loader_if.sv | 45 ++++
 rtl/imem_loader.sv | 145 ++++++++++++++
 tb/tb_imem_loader.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
//
// Bundles the two buses of the instruction-memory loader:
//   * byte stream in  : in_valid, in_data[7:0], in_last  (source -> loader)
//                       in_ready                         (loader -> source)
//   * memory write    : wr_en, wr_addr[ADDR_W-1:0], wr_data[31:0]
//                                                        (loader -> memory)
//
// Modports:
//   master - the environment side (byte source plus instruction memory)
//   slave  - the loader itself
// ---------------------------------------------------------------------------
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Fills the instruction store of the single-cycle datapath. Bytes arrive on a
// valid/ready stream, are packed big-endian (first byte -> [31:24]) into
// 32-bit words and written at byte addresses 0, 4, 8, ... . The CPU is held
// (cpu_run = 0) until a complete image has been written.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   load_req  in   one-cycle pulse starting a new image load
//   bus       slave modport of imem_loader_if (byte stream + memory write)
//   cpu_run   out  1 = image valid, PC may advance
//   words     out  number of words written by the current/last load
//   ovf       out  image was longer than WORDS words
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int WORDS  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    imem_loader_if.slave      bus,
    output logic              cpu_run,
    output logic [6:0]        words,
    output logic              ovf
);

    typedef enum logic [1:0] {
        IDLE,
        ASSEMBLE,
        WRITE,
        DONE
    } state_t;

    // Address of the final word slot; writing here without in_last ends the load.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(4 * (WORDS - 1));

    state_t            state;
    state_t            next_state;

    logic [ADDR_W-1:0] addr;
    logic [1:0]        byte_cnt;
    logic [31:0]       word_buf;
    logic              last_seen;

    logic              accept;
    logic              at_end;
    logic              start;

    assign accept = (state == ASSEMBLE) && bus.in_valid;
    assign at_end = (addr == LAST_ADDR);
    // load_req only has an effect from the two resting states.
    assign start  = load_req && ((state == IDLE) || (state == DONE));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (load_req) begin
                    next_state = ASSEMBLE;
                end
            end
            ASSEMBLE: begin
                if (accept && ((byte_cnt == 2'd3) || bus.in_last)) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (last_seen || at_end) begin
                    next_state = DONE;
                end else begin
                    next_state = ASSEMBLE;
                end
            end
            DONE: begin
                if (load_req) begin
                    next_state = ASSEMBLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Word assembly, address/word counters and overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            byte_cnt  <= 2'd0;
            word_buf  <= 32'd0;
            last_seen <= 1'b0;
            words     <= 7'd0;
            ovf       <= 1'b0;
        end else if (start) begin
            addr      <= '0;
            byte_cnt  <= 2'd0;
            word_buf  <= 32'd0;
            last_seen <= 1'b0;
            words     <= 7'd0;
            ovf       <= 1'b0;
        end else if (accept) begin
            // Bytes land in their final big-endian lane, so a word cut short
            // by in_last is already zero-padded in its low bytes.
            case (byte_cnt)
                2'd0:    word_buf[31:24] <= bus.in_data;
                2'd1:    word_buf[23:16] <= bus.in_data;
                2'd2:    word_buf[15:8]  <= bus.in_data;
                default: word_buf[7:0]   <= bus.in_data;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
            if (bus.in_last) begin
                last_seen <= 1'b1;
            end
        end else if (state == WRITE) begin
            addr     <= addr + ADDR_W'(4);
            words    <= words + 7'd1;
            byte_cnt <= 2'd0;
            word_buf <= 32'd0;
            if (!last_seen && at_end) begin
                ovf <= 1'b1;
            end
        end
    end

    // Outputs are decoded from registered state only; the write bus is
    // forced to zero outside WRITE so wr_addr never shows the wrapped addr.
    assign bus.in_ready = (state == ASSEMBLE);
    assign bus.wr_en    = (state == WRITE);
    assign bus.wr_addr  = (state == WRITE) ? addr : '0;
    assign bus.wr_data  = (state == WRITE) ? word_buf : 32'd0;
    assign cpu_run      = (state == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Drives byte images into imem_loader and compares the memory writes, word
// count, overflow flag and run handshake against a reference model that
// computes the expected image directly from the byte list.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    logic       clk;
    logic       rst_n;
    logic       load_req;
    logic       cpu_run;
    logic [6:0] words;
    logic       ovf;

    imem_loader_if #(.ADDR_W(8)) bus_if ();

    imem_loader #(.ADDR_W(8), .WORDS(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_req (load_req),
        .bus      (bus_if),
        .cpu_run  (cpu_run),
        .words    (words),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor (samples on falling edge) ----------------
    int          cyc = 0;
    int          acc_cnt = 0;
    int          rdy_in_wr = 0;
    int          run_cyc = -1;
    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];

    always @(negedge clk) begin
        cyc++;
        if (bus_if.in_valid && bus_if.in_ready) acc_cnt++;
        if (bus_if.wr_en) begin
            wa_q.push_back(bus_if.wr_addr);
            wd_q.push_back(bus_if.wr_data);
            wc_q.push_back(cyc);
            if (bus_if.in_ready) rdy_in_wr++;
        end
        if (cpu_run && run_cyc < 0) run_cyc = cyc;
    end

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        acc_cnt   = 0;
        rdy_in_wr = 0;
        run_cyc   = -1;
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  img [0:299];
    logic [31:0] exp_data [0:63];
    int          exp_bytes [0:63];
    int          exp_n;
    int          exp_cons;
    bit          exp_ovf;

    // An image ends at its flagged byte, or after 256 bytes (64 words) with
    // the overflow flag when no flag appears in time.
    task automatic model(input int last_idx);
        if (last_idx >= 0 && last_idx < 256) begin
            exp_cons = last_idx + 1;
            exp_ovf  = 1'b0;
        end else begin
            exp_cons = 256;
            exp_ovf  = 1'b1;
        end
        exp_n = (exp_cons + 3) / 4;
        for (int w = 0; w < exp_n; w++) begin
            exp_data[w]  = 32'd0;
            exp_bytes[w] = 0;
            for (int k = 0; k < 4; k++) begin
                if (4 * w + k < exp_cons) begin
                    exp_data[w]  = exp_data[w] | (32'(img[4 * w + k]) << (24 - 8 * k));
                    exp_bytes[w] = exp_bytes[w] + 1;
                end
            end
        end
    endtask

    // ---------------- drivers (entered just after a rising edge) ----------------
    task automatic start_load(input string tag);
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        clear_mon();
        chk({tag, "_ready_after_load"}, 32'(bus_if.in_ready), 32'd1);
        chk({tag, "_run_dropped"}, 32'(cpu_run), 32'd0);
    endtask

    task automatic send(input int n, input bit hold, input bit poke, input int last_idx);
        int  idx = 0;
        int  guard = 0;
        bit  acc;
        bit  stop;
        while (idx < n && guard < 3000) begin
            bus_if.in_valid = hold ? 1'b1 : ($urandom_range(0, 2) != 0);
            bus_if.in_data  = img[idx];
            bus_if.in_last  = (idx == last_idx);
            load_req        = poke && !cpu_run && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            acc  = bus_if.in_valid && bus_if.in_ready;
            stop = cpu_run;
            @(posedge clk);
            #1;
            if (acc) idx++;
            if (stop) break;
            guard++;
        end
        bus_if.in_valid = 1'b0;
        bus_if.in_last  = 1'b0;
        load_req        = 1'b0;
    endtask

    task automatic wait_run();
        for (int i = 0; i < 50 && !cpu_run; i++) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_load(input string tag, input bit hold);
        int nw;
        model_guard: begin end
        chk({tag, "_consumed"}, 32'(acc_cnt), 32'(exp_cons));
        chk({tag, "_nwrites"}, 32'(wa_q.size()), 32'(exp_n));
        nw = (wa_q.size() < exp_n) ? wa_q.size() : exp_n;
        for (int w = 0; w < nw; w++) begin
            chk($sformatf("%s_addr%0d", tag, w), 32'(wa_q[w]), 32'(4 * w));
            chk($sformatf("%s_data%0d", tag, w), wd_q[w], exp_data[w]);
            if (hold && w > 0)
                chk($sformatf("%s_gap%0d", tag, w), 32'(wc_q[w] - wc_q[w - 1]), 32'(exp_bytes[w] + 1));
        end
        if (nw > 0) chk({tag, "_run_latency"}, 32'(run_cyc - wc_q[nw - 1]), 32'd1);
        chk({tag, "_cpu_run"}, 32'(cpu_run), 32'd1);
        chk({tag, "_words"}, 32'(words), 32'(exp_n));
        chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        chk({tag, "_ready_done"}, 32'(bus_if.in_ready), 32'd0);
        chk({tag, "_ready_in_write"}, 32'(rdy_in_wr), 32'd0);
    endtask

    task automatic run_image(input string tag, input int n, input bit hold, input bit poke,
                             input int last_idx);
        model(last_idx);
        start_load(tag);
        send(n, hold, poke, last_idx);
        wait_run();
        check_load(tag, hold);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(bus_if.in_ready), 32'd0);
        chk({tag, "_wr_en"}, 32'(bus_if.wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(bus_if.wr_addr), 32'd0);
        chk({tag, "_wr_data"}, bus_if.wr_data, 32'd0);
        chk({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
        chk({tag, "_words"}, 32'(words), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation did not finish");
    end

    // ---------------- main sequence ----------------
    initial begin
        int len;

        rst_n           = 1'b0;
        load_req        = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = 8'd0;
        bus_if.in_last  = 1'b0;

        // Reset values, then stream bytes with no load_req
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_mon();
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 8'h5A;
        repeat (6) begin
            @(negedge clk);
            chk("idle_ready", 32'(bus_if.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        chk("idle_writes", 32'(wa_q.size()), 32'd0);
        chk("idle_consumed", 32'(acc_cnt), 32'd0);
        chk("idle_run", 32'(cpu_run), 32'd0);

        // Two-word image
        img[0] = 8'h20; img[1] = 8'h08; img[2] = 8'h00; img[3] = 8'h05;
        img[4] = 8'h01; img[5] = 8'h09; img[6] = 8'h50; img[7] = 8'h20;
        run_image("two", 8, 1'b1, 1'b0, 7);
        chk("two_w0_literal", wd_q.size() > 0 ? wd_q[0] : 32'hDEAD_BEEF, 32'h2008_0005);
        chk("two_w1_literal", wd_q.size() > 1 ? wd_q[1] : 32'hDEAD_BEEF, 32'h0109_5020);

        // Partial final word
        img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC; img[3] = 8'hDD; img[4] = 8'hEE;
        run_image("part", 5, 1'b1, 1'b0, 4);
        chk("part_w1_literal", wd_q.size() > 1 ? wd_q[1] : 32'hDEAD_BEEF, 32'hEE00_0000);

        // Overflow: 260 bytes, no in_last; leftover bytes must stay unconsumed
        for (int i = 0; i < 260; i++) img[i] = 8'($urandom);
        model(-1);
        start_load("ovf");
        send(260, 1'b1, 1'b0, -1);
        wait_run();
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = img[256];
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        check_load("ovf", 1'b1);
        chk("ovf_last_addr", wa_q.size() > 0 ? 32'(wa_q[wa_q.size() - 1]) : 32'hFFFF, 32'h0000_00FC);

        // Random images with gaps in in_valid and stray load_req pulses
        for (int t = 0; t < 6; t++) begin
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) img[i] = 8'($urandom);
            run_image($sformatf("rnd%0d", t), len, 1'b0, 1'b1, len - 1);
        end

        // Random image with in_valid held (throughput)
        len = $urandom_range(9, 30);
        for (int i = 0; i < len; i++) img[i] = 8'($urandom);
        run_image("hold", len, 1'b1, 1'b0, len - 1);

        // Reset after 6 bytes: immediate return to IDLE
        for (int i = 0; i < 12; i++) img[i] = 8'($urandom);
        start_load("mid");
        send(6, 1'b1, 1'b0, -1);
        chk("mid_words_before", 32'(words), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset during the write cycle drops wr_en without a clock edge
        start_load("wrst");
        send(4, 1'b1, 1'b0, -1);
        chk("wrst_wr_en_before", 32'(bus_if.wr_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("wrst_wr_en_after", 32'(bus_if.wr_en), 32'd0);
        chk("wrst_wr_data_after", bus_if.wr_data, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full reload after reset starts again at address 0
        for (int i = 0; i < 10; i++) img[i] = 8'($urandom);
        run_image("reload", 10, 1'b1, 1'b0, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
